// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared definitions for the run controller.
//   state_t    - controller FSM states
//   CNT_W      - width of the RUN cycle counter
//   BASE_ADDR  - program base addresses, program 1..3 in order
//   base_for() - base address for a 1-based program number
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int CNT_W     = 16;
    localparam int NPROG_MAX = 3;

    localparam int BASE_ADDR [NPROG_MAX] = '{0, 100, 200};

    // Program numbers are 1-based because ProgIdx is already incremented
    // by the time the LOAD state issues the address.
    function automatic int base_for(input logic [1:0] prog_num);
        case (prog_num)
            2'd1:    return BASE_ADDR[0];
            2'd2:    return BASE_ADDR[1];
            2'd3:    return BASE_ADDR[2];
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/start_edge.sv
// start_edge: registers the Start request once and reports its edges.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (clears the registered copy)
//   din  - raw request level
//   rise - din high now, low last cycle
//   fall - din low now, high last cycle
module start_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences a series of test programs on a small CPU.
//   Clk, Reset - clock and synchronous active-high reset
//   Start      - request level from the bench; one pulse per program
//   Halt       - decoded halt instruction, only honoured in RUN
//   PcLoad     - one-cycle PC load strobe (LOAD state only)
//   PcLoadVal  - base address of the program being loaded, 0 otherwise
//   PcEn       - PC may advance (RUN state only)
//   Ack        - current program finished (DONE state)
//   ProgIdx    - programs accepted since reset, saturates at NPROG
//   CycleCnt   - RUN cycles of the current/last program, saturating
//   dbg_state  - current FSM state
// Handshake: a Start rise in IDLE/DONE arms the next program, the
// following Start fall launches it; Ack stays high until the next
// accepted rise. All outputs decode from registered state only.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int A     = 10,
    parameter int NPROG = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             PcLoad,
    output logic [A-1:0]     PcLoadVal,
    output logic             PcEn,
    output logic             Ack,
    output logic [1:0]       ProgIdx,
    output logic [CNT_W-1:0] CycleCnt,
    output state_t           dbg_state
);

    localparam logic [1:0] NPROG_L = 2'(NPROG);

    logic rise;
    logic fall;

    state_t           state_q, state_d;
    logic [1:0]       prog_idx_q, prog_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    start_edge u_start_edge (
        .clk  (Clk),
        .rst  (Reset),
        .din  (Start),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            prog_idx_q <= 2'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prog_idx_d = prog_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A rise past the last program is dropped without a trace.
                if (rise && (prog_idx_q < NPROG_L)) begin
                    state_d    = S_ARMED;
                    prog_idx_d = prog_idx_q + 2'd1;
                end
            end
            S_ARMED: begin
                // Clearing here makes CycleCnt read 0 during LOAD.
                if (fall) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Halt wins over any Start edge in the same cycle.
                if (Halt) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign PcLoad    = (state_q == S_LOAD);
    assign PcLoadVal = (state_q == S_LOAD) ? A'(base_for(prog_idx_q)) : '0;
    assign PcEn      = (state_q == S_RUN);
    assign Ack       = (state_q == S_DONE);
    assign ProgIdx   = prog_idx_q;
    assign CycleCnt  = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: scenario tasks with inline checks, a PcLoad
// scoreboard fed by a high-level program-series model, and a final report.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int A = 10;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Halt;
    logic         PcLoad;
    logic [A-1:0] PcLoadVal;
    logic         PcEn;
    logic         Ack;
    logic [1:0]   ProgIdx;
    logic [15:0]  CycleCnt;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;

    // Model: programs accepted since reset, and base addresses still owed.
    int model_progs = 0;
    logic [A-1:0] exp_q[$];

    always #5 Clk = ~Clk;

    run_ctrl #(.A(A), .NPROG(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .PcLoad    (PcLoad),
        .PcLoadVal (PcLoadVal),
        .PcEn      (PcEn),
        .Ack       (Ack),
        .ProgIdx   (ProgIdx),
        .CycleCnt  (CycleCnt),
        .dbg_state (dbg_state)
    );

    // Scoreboard: every load strobe must match the next owed base address.
    always @(negedge Clk) begin
        if (PcLoad === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_load: got load of %0d, expected no load", PcLoadVal);
                bad++;
            end else begin
                logic [A-1:0] e;
                e = exp_q.pop_front();
                if (PcLoadVal !== e) begin
                    $display("FAIL sb_load_val: got %0d, expected %0d", PcLoadVal, e);
                    bad++;
                end
            end
        end
    end

    function automatic logic [A-1:0] model_base(input int k);
        return A'((k - 1) * 100);
    endfunction

    // Returns 1 when the model accepts a new program on a Start rise.
    function automatic bit model_accept();
        if (model_progs < 3) begin
            model_progs++;
            exp_q.push_back(model_base(model_progs));
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        model_progs = 0;
        exp_q.delete();
    endtask

    // Drives a full Start pulse; returns in the LOAD cycle.
    task automatic go_prog(input int hold);
        void'(model_accept());
        Start = 1'b1;
        repeat (hold) tick();
        Start = 1'b0;
        tick();
    endtask

    // From LOAD: enters RUN and halts on the len-th RUN cycle.
    task automatic run_prog(input int len);
        tick();
        for (int i = 0; i < len; i++) begin
            Halt = (i == len - 1);
            tick();
        end
        Halt = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({PcEn, PcLoad, PcLoadVal, ProgIdx, Ack, CycleCnt} !== '0 || dbg_state !== S_IDLE) begin
                $display("FAIL reset_idle: cycle %0d got en=%b ld=%b val=%0d idx=%0d ack=%b cnt=%0d, expected all 0",
                         i, PcEn, PcLoad, PcLoadVal, ProgIdx, Ack, CycleCnt);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_first_program();
        void'(model_accept());
        Start = 1'b1;
        tick();
        total++;
        if (dbg_state !== S_ARMED || ProgIdx !== 2'd1 || PcLoad !== 1'b0 || PcEn !== 1'b0) begin
            $display("FAIL first_armed: got state=%0d idx=%0d ld=%b en=%b, expected ARMED idx=1 ld=0 en=0",
                     dbg_state, ProgIdx, PcLoad, PcEn);
            bad++;
        end
        tick();
        tick();
        Start = 1'b0;
        tick();
        total++;
        if (PcLoad !== 1'b1 || PcLoadVal !== 10'd0 || PcEn !== 1'b0 || CycleCnt !== 16'd0) begin
            $display("FAIL first_load: got ld=%b val=%0d en=%b cnt=%0d, expected ld=1 val=0 en=0 cnt=0",
                     PcLoad, PcLoadVal, PcEn, CycleCnt);
            bad++;
        end
        tick();
        for (int i = 0; i < 57; i++) begin
            total++;
            if (PcEn !== 1'b1 || PcLoad !== 1'b0 || CycleCnt !== 16'(i)) begin
                $display("FAIL first_run: cycle %0d got en=%b ld=%b cnt=%0d, expected en=1 ld=0 cnt=%0d",
                         i, PcEn, PcLoad, CycleCnt, i);
                bad++;
            end
            Halt = (i == 56);
            tick();
        end
        Halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (Ack !== 1'b1 || PcEn !== 1'b0 || CycleCnt !== 16'd57 || ProgIdx !== 2'd1) begin
                $display("FAIL first_done: got ack=%b en=%b cnt=%0d idx=%0d, expected ack=1 en=0 cnt=57 idx=1",
                         Ack, PcEn, CycleCnt, ProgIdx);
                bad++;
            end
            Halt = 1'b1;   // ignored outside RUN
            tick();
        end
        Halt = 1'b0;
    endtask

    task automatic test_next_programs();
        for (int p = 2; p <= 3; p++) begin
            int len;
            void'(model_accept());
            Start = 1'b1;
            tick();
            total++;
            if (Ack !== 1'b0 || ProgIdx !== 2'(p) || dbg_state !== S_ARMED) begin
                $display("FAIL next_rise: prog %0d got ack=%b idx=%0d state=%0d, expected ack=0 idx=%0d ARMED",
                         p, Ack, ProgIdx, dbg_state, p);
                bad++;
            end
            repeat ($urandom_range(0, 4)) begin
                Halt = 1'($urandom_range(0, 1));
                tick();
            end
            Halt  = 1'b0;
            Start = 1'b0;
            tick();
            total++;
            if (PcLoad !== 1'b1 || PcLoadVal !== model_base(p)) begin
                $display("FAIL next_load: prog %0d got ld=%b val=%0d, expected ld=1 val=%0d",
                         p, PcLoad, PcLoadVal, model_base(p));
                bad++;
            end
            len = $urandom_range(1, 40);
            run_prog(len);
            total++;
            if (Ack !== 1'b1 || PcEn !== 1'b0 || CycleCnt !== 16'(len)) begin
                $display("FAIL next_done: prog %0d got ack=%b en=%b cnt=%0d, expected ack=1 en=0 cnt=%0d",
                         p, Ack, PcEn, CycleCnt, len);
                bad++;
            end
        end
        // Fourth pulse: beyond the series, must leave everything untouched.
        void'(model_accept());
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (dbg_state !== S_DONE || ProgIdx !== 2'd3 || Ack !== 1'b1 || PcLoad !== 1'b0) begin
                $display("FAIL fourth_ignored: got state=%0d idx=%0d ack=%b ld=%b, expected DONE idx=3 ack=1 ld=0",
                         dbg_state, ProgIdx, Ack, PcLoad);
                bad++;
            end
        end
    endtask

    task automatic test_halt_with_rise();
        do_reset();
        go_prog($urandom_range(1, 4));
        tick();
        repeat ($urandom_range(2, 10)) tick();
        Start = 1'b1;
        Halt  = 1'b1;
        tick();
        Halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (dbg_state !== S_DONE || ProgIdx !== 2'd1 || PcLoad !== 1'b0 || Ack !== 1'b1) begin
                $display("FAIL halt_rise: cycle %0d got state=%0d idx=%0d ld=%b ack=%b, expected DONE idx=1 ld=0 ack=1",
                         i, dbg_state, ProgIdx, PcLoad, Ack);
                bad++;
            end
            tick();
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        go_prog(1);
        run_prog(5);
        go_prog(2);
        tick();
        repeat (3) tick();
        Reset = 1'b1;
        Start = 1'b1;
        Halt  = 1'b1;
        tick();
        total++;
        if (dbg_state !== S_IDLE || {PcEn, PcLoad, PcLoadVal, ProgIdx, Ack, CycleCnt} !== '0) begin
            $display("FAIL reset_run: got state=%0d en=%b ld=%b idx=%0d ack=%b cnt=%0d, expected IDLE all 0",
                     dbg_state, PcEn, PcLoad, ProgIdx, Ack, CycleCnt);
            bad++;
        end
        Reset = 1'b0;
        Start = 1'b0;
        Halt  = 1'b0;
        model_progs = 0;
        exp_q.delete();
        tick();
        go_prog(2);
        total++;
        if (PcLoad !== 1'b1 || PcLoadVal !== 10'd0 || ProgIdx !== 2'd1) begin
            $display("FAIL reset_restart: got ld=%b val=%0d idx=%0d, expected ld=1 val=0 idx=1",
                     PcLoad, PcLoadVal, ProgIdx);
            bad++;
        end
        // Reset in the middle of LOAD: the strobe must not outlive the reset edge.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_progs = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (PcLoad !== 1'b0 || PcEn !== 1'b0 || dbg_state !== S_IDLE) begin
                $display("FAIL reset_load: got ld=%b en=%b state=%0d, expected ld=0 en=0 IDLE",
                         PcLoad, PcEn, dbg_state);
                bad++;
            end
            tick();
        end
    endtask

    task automatic test_random_series();
        do_reset();
        for (int p = 0; p < 6; p++) begin
            int  hold;
            int  len;
            bit  acc;
            logic [1:0] exp_idx;
            hold = $urandom_range(1, 4);
            acc  = model_accept();
            exp_idx = 2'(model_progs);
            Start = 1'b1;
            tick();
            total++;
            if (ProgIdx !== exp_idx || Ack !== !acc) begin
                $display("FAIL rnd_rise: pulse %0d got idx=%0d ack=%b, expected idx=%0d ack=%b",
                         p, ProgIdx, Ack, exp_idx, !acc);
                bad++;
            end
            repeat (hold - 1) begin
                Halt = 1'($urandom_range(0, 1));
                tick();
            end
            Halt  = 1'b0;
            Start = 1'b0;
            tick();
            if (!acc) begin
                total++;
                if (dbg_state !== S_DONE || PcLoad !== 1'b0 || Ack !== 1'b1) begin
                    $display("FAIL rnd_ignored: pulse %0d got state=%0d ld=%b ack=%b, expected DONE ld=0 ack=1",
                             p, dbg_state, PcLoad, Ack);
                    bad++;
                end
                continue;
            end
            total++;
            if (PcLoad !== 1'b1 || PcLoadVal !== model_base(model_progs)) begin
                $display("FAIL rnd_load: pulse %0d got ld=%b val=%0d, expected ld=1 val=%0d",
                         p, PcLoad, PcLoadVal, model_base(model_progs));
                bad++;
            end
            tick();
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                total++;
                if (PcEn !== 1'b1 || CycleCnt !== 16'(i) || ProgIdx !== exp_idx) begin
                    $display("FAIL rnd_run: pulse %0d cycle %0d got en=%b cnt=%0d idx=%0d, expected en=1 cnt=%0d idx=%0d",
                             p, i, PcEn, CycleCnt, ProgIdx, i, exp_idx);
                    bad++;
                end
                // Start edges during RUN are noise and must be ignored.
                Start = (i < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                Halt  = (i == len - 1);
                tick();
            end
            Halt = 1'b0;
            total++;
            if (Ack !== 1'b1 || PcEn !== 1'b0 || CycleCnt !== 16'(len)) begin
                $display("FAIL rnd_done: pulse %0d got ack=%b en=%b cnt=%0d, expected ack=1 en=0 cnt=%0d",
                         p, Ack, PcEn, CycleCnt, len);
                bad++;
            end
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        test_reset();
        test_first_program();
        test_next_programs();
        test_halt_with_rise();
        test_reset_abort();
        test_random_series();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_drain: got %0d loads outstanding, expected 0", exp_q.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
